// File: rtl/fb_access_sched_pkg.sv
// Shared widths, clear-FSM state and write-request type for the framebuffer scheduler.
package fb_pkg;

  localparam int FB_HOR_W  = 7;
  localparam int FB_VER_W  = 8;
  localparam int FB_PIX_W  = 6;
  localparam int FB_ADDR_W = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_clr_state_e;

  typedef struct packed {
    logic [FB_VER_W-1:0] ver;
    logic [FB_HOR_W-1:0] hor;
    logic [FB_PIX_W-1:0] data;
  } fb_wr_req_t;

  // RAM address is simply row above column.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_VER_W-1:0] ver,
                                                   input logic [FB_HOR_W-1:0] hor);
    return {ver, hor};
  endfunction

endpackage

// File: rtl/fb_access_sched_if.sv
// Pixel-write producer handshake: master = drawing logic, slave = scheduler.
interface fb_access_sched_if;
  import fb_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [FB_HOR_W-1:0] wr_hor;
  logic [FB_VER_W-1:0] wr_ver;
  logic [FB_PIX_W-1:0] wr_data;

  modport master (output wr_valid, wr_hor, wr_ver, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_hor, wr_ver, wr_data, output wr_ready);

endinterface

// File: rtl/fb_access_sched_wr_fifo.sv
// Synchronous write-request FIFO; DEPTH must be a power of two, >= 2.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  fb_wr_req_t din,
  output fb_wr_req_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  fb_wr_req_t    mem_r [DEPTH];
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/fb_access_sched.sv
// Framebuffer RAM port scheduler: VGA reads first, then clear sweep, then queued pixel writes.
// Optional macro FB_IDLE_WRITE_EN: writes may use any non-read cycle, not only vga_write slots.
module fb_access_sched
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_ROWS   = 150,
  parameter int CLR_COLS   = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vga_read,
  input  logic                 vga_write,
  input  logic [FB_HOR_W-1:0]  vga_hor_addr,
  input  logic [FB_VER_W-1:0]  vga_ver_addr,
  output logic [FB_PIX_W-1:0]  vga_data,
  fb_access_sched_if.slave     wr,
  input  logic                 clr_req,
  input  logic [FB_PIX_W-1:0]  clr_color,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic                 ram_we,
  output logic [FB_PIX_W-1:0]  ram_wdata,
  input  logic [FB_PIX_W-1:0]  ram_rdata
);

  localparam logic [FB_HOR_W-1:0] COL_LAST = FB_HOR_W'(CLR_COLS - 1);
  localparam logic [FB_VER_W-1:0] ROW_LAST = FB_VER_W'(CLR_ROWS - 1);

  fb_clr_state_e        state_r, state_n;
  logic [FB_VER_W-1:0]  row_r, row_n;
  logic [FB_HOR_W-1:0]  col_r, col_n;
  logic [FB_PIX_W-1:0]  color_r, color_n;
  logic                 done_r, done_n;
  logic [FB_ADDR_W-1:0] last_addr_r;
  logic                 rd_q_r;
  logic [FB_PIX_W-1:0]  vga_data_r;
  logic                 write_slot_s;
  logic                 clr_wr_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  fb_wr_req_t           head_s;
  fb_wr_req_t           push_req_s;

`ifdef FB_IDLE_WRITE_EN
  assign write_slot_s = 1'b1;
`else
  assign write_slot_s = vga_write;
`endif

  assign push_req_s  = '{ver: wr.wr_ver, hor: wr.wr_hor, data: wr.wr_data};
  assign wr.wr_ready = ~fifo_full_s;
  assign clr_busy    = (state_r == ST_CLEAR);
  assign clr_done    = done_r;
  assign vga_data    = vga_data_r;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr.wr_valid),
    .pop   (pop_s),
    .din   (push_req_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Per-cycle RAM port grant; an idle port keeps presenting the previous address.
  always_comb begin
    clr_wr_s  = 1'b0;
    pop_s     = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = {FB_PIX_W{1'b0}};
    ram_addr  = last_addr_r;
    if (vga_read) begin
      ram_addr = fb_addr(vga_ver_addr, vga_hor_addr);
    end else if (write_slot_s && (state_r == ST_CLEAR)) begin
      clr_wr_s  = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = fb_addr(row_r, col_r);
      ram_wdata = color_r;
    end else if (write_slot_s && !fifo_empty_s) begin
      pop_s     = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = fb_addr(head_s.ver, head_s.hor);
      ram_wdata = head_s.data;
    end else begin
      ram_addr  = last_addr_r;
    end
  end

  // Clear FSM next state: the sweep only moves on granted clear writes.
  always_comb begin
    state_n = state_r;
    row_n   = row_r;
    col_n   = col_r;
    color_n = color_r;
    done_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_n = ST_CLEAR;
          row_n   = {FB_VER_W{1'b0}};
          col_n   = {FB_HOR_W{1'b0}};
          color_n = clr_color;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_wr_s) begin
          if (col_r == COL_LAST) begin
            col_n = {FB_HOR_W{1'b0}};
            if (row_r == ROW_LAST) begin
              state_n = ST_IDLE;
              row_n   = {FB_VER_W{1'b0}};
              done_n  = 1'b1;
            end else begin
              row_n = row_r + 8'd1;
            end
          end else begin
            col_n = col_r + 7'd1;
          end
        end else begin
          state_n = ST_CLEAR;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, sweep counters, held address and the one-cycle-late VGA pixel capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      row_r       <= {FB_VER_W{1'b0}};
      col_r       <= {FB_HOR_W{1'b0}};
      color_r     <= {FB_PIX_W{1'b0}};
      done_r      <= 1'b0;
      last_addr_r <= {FB_ADDR_W{1'b0}};
      rd_q_r      <= 1'b0;
      vga_data_r  <= {FB_PIX_W{1'b0}};
    end else begin
      state_r     <= state_n;
      row_r       <= row_n;
      col_r       <= col_n;
      color_r     <= color_n;
      done_r      <= done_n;
      last_addr_r <= ram_addr;
      rd_q_r      <= vga_read;
      vga_data_r  <= rd_q_r ? ram_rdata : {FB_PIX_W{1'b0}};
    end
  end

endmodule
